// File: rtl/imm_gen_queue.sv
// -----------------------------------------------------------------------------
// imm_gen_queue
//   Buffered immediate generator for the decode stage. Each fetched instruction
//   is classified by opcode and its immediate is extracted, extended and, for
//   MOVZ/MOVK, shifted by 16*hw. A MOVK merge mask and an out-of-range flag are
//   produced alongside. Decoded results sit in a DEPTH-entry FIFO so decode can
//   stall without a combinational back-pressure path to fetch.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous FIFO empty (beats push and pop)
//   in_valid/in_ready instruction handshake (in_ready = count < DEPTH)
//   instruction       raw instruction word
//   in_tag            sideband tag stored with the instruction
//   out_valid/out_ready  head-entry handshake
//   imm               extended / shifted immediate of the head entry
//   imm_mask          ones over the MOVK field, zeros otherwise
//   imm_class         0 SHAMT 1 ALU12 2 DT9 3 CB19 4 BR26 5 MOVW 6 ZERO 7 RAW
//   imm_err           MOVW shift would place the field beyond WORD
//   out_tag           tag of the head entry
// -----------------------------------------------------------------------------
module imm_gen_queue #(
    parameter int WORD         = 64,
    parameter int INSTR_LEN    = 32,
    parameter int DEPTH        = 2,
    parameter int TAG_W        = 8,
    parameter int MOV_SHIFT_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_LEN-1:0] instruction,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD-1:0]      imm,
    output logic [WORD-1:0]      imm_mask,
    output logic [2:0]           imm_class,
    output logic                 imm_err,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Opcode encodings shared with the rest of the decode stage.
    localparam logic [10:0] OP_LSL   = 11'h69B;
    localparam logic [10:0] OP_LSR   = 11'h69A;
    localparam logic [10:0] OP_LDUR  = 11'h7C2;
    localparam logic [10:0] OP_LDURS = 11'h5E2;
    localparam logic [10:0] OP_LDURD = 11'h7E2;
    localparam logic [10:0] OP_STUR  = 11'h7C0;
    localparam logic [10:0] OP_STURS = 11'h5E0;
    localparam logic [10:0] OP_STURD = 11'h7E0;
    localparam logic [10:0] OP_LDA   = 11'h7C5;
    localparam logic [10:0] OP_MOV   = 11'h550;
    localparam logic [9:0]  OP_ADDI  = 10'h244;
    localparam logic [9:0]  OP_ANDI  = 10'h248;
    localparam logic [9:0]  OP_EORI  = 10'h348;
    localparam logic [9:0]  OP_ORRI  = 10'h2C8;
    localparam logic [9:0]  OP_SUBI  = 10'h344;
    localparam logic [9:0]  OP_CMPI  = 10'h3C4;
    localparam logic [8:0]  OP_MOVZ  = 9'h1A5;
    localparam logic [8:0]  OP_MOVK  = 9'h1E5;
    localparam logic [7:0]  OP_CBZ   = 8'hB4;
    localparam logic [7:0]  OP_CBNZ  = 8'hB5;
    localparam logic [7:0]  OP_BCOND = 8'h54;
    localparam logic [5:0]  OP_B     = 6'h05;
    localparam logic [5:0]  OP_BL    = 6'h25;

    localparam logic [2:0] C_SHAMT = 3'd0;
    localparam logic [2:0] C_ALU12 = 3'd1;
    localparam logic [2:0] C_DT9   = 3'd2;
    localparam logic [2:0] C_CB19  = 3'd3;
    localparam logic [2:0] C_BR26  = 3'd4;
    localparam logic [2:0] C_MOVW  = 3'd5;
    localparam logic [2:0] C_ZERO  = 3'd6;
    localparam logic [2:0] C_RAW   = 3'd7;

    typedef struct packed {
        logic [WORD-1:0]  imm;
        logic [WORD-1:0]  mask;
        logic [2:0]       cls;
        logic             err;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // Sign-extend the low 'width' bits of field to WORD bits.
    function automatic logic [WORD-1:0] sext(input logic [25:0] field, input int width);
        logic signed [WORD-1:0] t;
        t = $signed(WORD'(field) << (WORD - width));
        return t >>> (WORD - width);
    endfunction

    logic [10:0] op11;
    logic [9:0]  op10;
    logic [8:0]  op9;
    logic [7:0]  op8;
    logic [5:0]  op6;
    logic [1:0]  hw;
    logic [5:0]  mov_sh;
    logic        mov_err;
    entry_t      dec;

    assign op11 = instruction[31:21];
    assign op10 = instruction[31:22];
    assign op9  = instruction[31:23];
    assign op8  = instruction[31:24];
    assign op6  = instruction[31:26];
    assign hw   = instruction[22:21];

    // hw range is checked against WORD regardless of whether the shift is applied.
    assign mov_sh  = (MOV_SHIFT_EN != 0) ? {hw, 4'b0000} : 6'd0;
    assign mov_err = (32'({hw, 4'b0000}) + 32'd16) > 32'(WORD);

    always_comb begin
        dec     = '0;
        dec.tag = in_tag;
        if (op11 == OP_LSL || op11 == OP_LSR) begin
            dec.cls = C_SHAMT;
            dec.imm = sext(26'(instruction[15:10]), 6);
        end else if (op11 == OP_LDUR || op11 == OP_LDURS || op11 == OP_LDURD ||
                     op11 == OP_STUR || op11 == OP_STURS || op11 == OP_STURD ||
                     op11 == OP_LDA) begin
            dec.cls = C_DT9;
            dec.imm = sext(26'(instruction[20:12]), 9);
        end else if (op11 == OP_MOV) begin
            dec.cls = C_ZERO;
        end else if (op10 == OP_ADDI || op10 == OP_ANDI || op10 == OP_EORI ||
                     op10 == OP_ORRI || op10 == OP_SUBI || op10 == OP_CMPI) begin
            dec.cls = C_ALU12;
            dec.imm = sext(26'(instruction[21:10]), 12);
        end else if (op9 == OP_MOVZ || op9 == OP_MOVK) begin
            dec.cls = C_MOVW;
            dec.err = mov_err;
            if (!mov_err) begin
                dec.imm = WORD'(instruction[20:5]) << mov_sh;
                if (op9 == OP_MOVK) begin
                    dec.mask = WORD'(16'hFFFF) << mov_sh;
                end
            end
        end else if (op8 == OP_CBZ || op8 == OP_CBNZ || op8 == OP_BCOND) begin
            dec.cls = C_CB19;
            dec.imm = sext(26'(instruction[23:5]), 19);
        end else if (op6 == OP_B || op6 == OP_BL) begin
            dec.cls = C_BR26;
            dec.imm = sext(instruction[25:0], 26);
        end else begin
            dec.cls = C_RAW;
            dec.imm = WORD'(instruction[31:0]);
        end
    end

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] rptr_nxt;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign in_ready  = count < CW'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign rptr_nxt  = rptr + PW'(1);

    // ---- enqueue: decoded entry written at the write pointer ----
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= dec;
        end
    end

    // ---- head register: tracks the oldest entry, holds when the queue empties ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            head  <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr_nxt;
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);

            // Next head is either already stored, or is the entry arriving now.
            if (pop && count > CW'(1)) begin
                head <= mem[rptr_nxt];
            end else if (push && (count == '0 || (pop && count == CW'(1)))) begin
                head <= dec;
            end
        end
    end

    assign imm       = head.imm;
    assign imm_mask  = head.mask;
    assign imm_class = head.cls;
    assign imm_err   = head.err;
    assign out_tag   = head.tag;

endmodule

// File: tb/tb_imm_gen_queue.sv
module tb_imm_gen_queue;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, imm_err;
    logic [31:0] instruction = '0;
    logic [7:0]  in_tag = '0, out_tag;
    logic [63:0] imm, imm_mask;
    logic [2:0]  imm_class;

    logic        s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic        s_in_ready, s_out_valid, s_err;
    logic [31:0] s_instr = '0;
    logic [7:0]  s_tag = '0, s_out_tag;
    logic [31:0] s_imm, s_mask;
    logic [2:0]  s_class;

    imm_gen_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .imm_mask(imm_mask), .imm_class(imm_class),
        .imm_err(imm_err), .out_tag(out_tag)
    );

    imm_gen_queue #(.WORD(32)) d32 (
        .clk(clk), .rst_n(rst_n), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .instruction(s_instr), .in_tag(s_tag),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .imm(s_imm), .imm_mask(s_mask), .imm_class(s_class),
        .imm_err(s_err), .out_tag(s_out_tag)
    );

    int total = 0;
    int bad   = 0;

    // Opcode table: prefix length, prefix value, immediate class.
    localparam int NOPS = 23;
    localparam int I_LSL = 0, I_ADDI = 2, I_LDUR = 8, I_CBZ = 15, I_B = 18,
                   I_MOVZ = 20, I_MOVK = 21, I_MOV = 22;
    int unsigned op_len [NOPS] = '{11, 11, 10, 10, 10, 10, 10, 10, 11, 11, 11, 11,
                                   11, 11, 11, 8, 8, 8, 6, 6, 9, 9, 11};
    int unsigned op_val [NOPS] = '{'h69B, 'h69A, 'h244, 'h248, 'h348, 'h2C8, 'h344,
                                   'h3C4, 'h7C2, 'h5E2, 'h7E2, 'h7C0, 'h5E0, 'h7E0,
                                   'h7C5, 'hB4, 'hB5, 'h54, 'h05, 'h25, 'h1A5, 'h1E5,
                                   'h550};
    int unsigned op_cls [NOPS] = '{0, 0, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2,
                                   3, 3, 3, 4, 4, 5, 5, 6};

    typedef struct {
        logic [63:0] imm;
        logic [63:0] mask;
        logic [2:0]  cls;
        logic        err;
        logic [7:0]  tag;
    } exp_t;

    exp_t q[$];

    function automatic logic [31:0] mk(int idx, logic [31:0] rest);
        logic [31:0] lowmask;
        lowmask = (32'd1 << (32 - op_len[idx])) - 32'd1;
        return (op_val[idx] << (32 - op_len[idx])) | (rest & lowmask);
    endfunction

    function automatic longint fld(logic [31:0] ins, int lo, int n);
        return longint'((ins >> lo) & ((32'd1 << n) - 32'd1));
    endfunction

    function automatic longint sx(longint f, int n);
        if (f >= (longint'(1) << (n - 1))) return f - (longint'(1) << n);
        return f;
    endfunction

    function automatic exp_t model(logic [31:0] ins, logic [7:0] tag, int w);
        exp_t        e;
        int          c;
        longint      v;
        longint      hw;
        logic [63:0] wm;
        c      = 7;
        v      = 0;
        e.tag  = tag;
        e.mask = '0;
        e.err  = 1'b0;
        for (int i = 0; i < NOPS; i++)
            if (c == 7 && (ins >> (32 - op_len[i])) == op_val[i]) c = int'(op_cls[i]);
        e.cls = 3'(c);
        wm = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        case (c)
            0: v = sx(fld(ins, 10, 6), 6);
            1: v = sx(fld(ins, 10, 12), 12);
            2: v = sx(fld(ins, 12, 9), 9);
            3: v = sx(fld(ins, 5, 19), 19);
            4: v = sx(fld(ins, 0, 26), 26);
            6: v = 0;
            7: v = longint'(ins);
            default: v = 0;
        endcase
        e.imm = 64'(v) & wm;
        if (c == 5) begin
            hw = fld(ins, 21, 2);
            if (16 * hw + 16 > w) begin
                e.err = 1'b1;
                e.imm = '0;
            end else begin
                e.imm = 64'(fld(ins, 5, 16)) * (64'd1 << (16 * hw));
                if ((ins >> 23) == 32'h1E5) e.mask = 64'hFFFF * (64'd1 << (16 * hw));
            end
        end
        return e;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus against the default instance, checked against the queue model.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [7:0] tg,
                         input logic ordy, input logic fl);
        logic ev, er, dpush, dpop;
        in_valid = v; instruction = ins; in_tag = tg; out_ready = ordy; flush = fl;
        #1;
        ev = q.size() > 0;
        er = q.size() < 2;
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("in_ready", 64'(in_ready), 64'(er));
        if (ev) begin
            chk("head_imm", imm, q[0].imm);
            chk("head_mask", imm_mask, q[0].mask);
            chk("head_class", 64'(imm_class), 64'(q[0].cls));
            chk("head_err", 64'(imm_err), 64'(q[0].err));
            chk("head_tag", 64'(out_tag), 64'(q[0].tag));
        end
        dpush = v && er && !fl;
        dpop  = ev && ordy && !fl;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (dpop) void'(q.pop_front());
            if (dpush) q.push_back(model(ins, tg, 64));
        end
        @(negedge clk);
    endtask

    // Push one instruction into an empty queue, check fixed expectations, pop it.
    task automatic push_check(string name, logic [31:0] ins, logic [63:0] e_imm,
                              logic [63:0] e_mask, logic [2:0] e_cls);
        cycle(1'b1, ins, 8'h5A, 1'b0, 1'b0);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_imm"}, imm, e_imm);
        chk({name, "_mask"}, imm_mask, e_mask);
        chk({name, "_class"}, 64'(imm_class), 64'(e_cls));
        cycle(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_imm", imm, 64'd0);
        chk("rst_mask", imm_mask, 64'd0);
        chk("rst_class", 64'(imm_class), 64'd0);
        chk("rst_err", 64'(imm_err), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADDI with imm12 = 0x800, tag 0x11
        cycle(1'b1, mk(I_ADDI, 32'h800 << 10), 8'h11, 1'b0, 1'b0);
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_imm", imm, 64'hFFFF_FFFF_FFFF_F800);
        chk("addi_class", 64'(imm_class), 64'd1);
        chk("addi_tag", 64'(out_tag), 64'h11);
        chk("addi_mask", imm_mask, 64'd0);
        cycle(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        push_check("movz", mk(I_MOVZ, (32'd2 << 21) | (32'hBEEF << 5)),
                   64'h0000_BEEF_0000_0000, 64'd0, 3'd5);
        push_check("movk", mk(I_MOVK, (32'd2 << 21) | (32'hBEEF << 5)),
                   64'h0000_BEEF_0000_0000, 64'h0000_FFFF_0000_0000, 3'd5);
        push_check("b_neg", mk(I_B, 32'h3FF_FFFF), 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3'd4);
        push_check("cbz", mk(I_CBZ, 32'h10 << 5), 64'h10, 64'd0, 3'd3);
        push_check("lsl", mk(I_LSL, 32'h3F << 10), 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3'd0);
        push_check("ldur", mk(I_LDUR, 32'h100 << 12), 64'hFFFF_FFFF_FFFF_FF00, 64'd0, 3'd2);
        push_check("mov", mk(I_MOV, 32'h001F_FFFF), 64'd0, 64'd0, 3'd6);
        push_check("raw", 32'h0000_0ABC, 64'h0ABC, 64'd0, 3'd7);
        push_check("movz_hw3", mk(I_MOVZ, (32'd3 << 21) | (32'h1234 << 5)),
                   64'h1234_0000_0000_0000, 64'd0, 3'd5);

        // 32-bit instance: hw=2 overflows, hw=1 fits
        s_in_valid = 1'b1;
        s_instr    = mk(I_MOVZ, (32'd2 << 21) | (32'hBEEF << 5));
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        chk("w32_err_valid", 64'(s_out_valid), 64'd1);
        chk("w32_err", 64'(s_err), 64'd1);
        chk("w32_err_imm", 64'(s_imm), 64'd0);
        chk("w32_err_mask", 64'(s_mask), 64'd0);
        chk("w32_err_class", 64'(s_class), 64'd5);
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("w32_drained", 64'(s_out_valid), 64'd0);
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_instr     = mk(I_MOVK, (32'd1 << 21) | (32'hBEEF << 5));
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        chk("w32_movk_imm", 64'(s_imm), 64'hBEEF_0000);
        chk("w32_movk_mask", 64'(s_mask), 64'hFFFF_0000);
        chk("w32_movk_err", 64'(s_err), 64'd0);
        s_flush = 1'b1;
        @(posedge clk); #1;
        s_flush = 1'b0;
        chk("w32_flush", 64'(s_out_valid), 64'd0);
        @(negedge clk);

        // Back-pressure: three pushes into a two-entry queue
        cycle(1'b1, mk(I_ADDI, 32'h1 << 10), 8'd1, 1'b0, 1'b0);
        cycle(1'b1, mk(I_ADDI, 32'h2 << 10), 8'd2, 1'b0, 1'b0);
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, mk(I_ADDI, 32'h3 << 10), 8'd3, 1'b0, 1'b0);
        chk("bp_tag1", 64'(out_tag), 64'd1);
        cycle(1'b1, mk(I_ADDI, 32'h3 << 10), 8'd3, 1'b1, 1'b0);
        chk("bp_tag2", 64'(out_tag), 64'd2);
        cycle(1'b1, mk(I_ADDI, 32'h3 << 10), 8'd3, 1'b1, 1'b0);
        chk("bp_tag3", 64'(out_tag), 64'd3);
        cycle(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Streaming: one result per cycle with pointer wrap
        for (int i = 0; i < 20; i++) begin
            r = $urandom;
            cycle(1'b1, mk(int'($urandom_range(0, NOPS - 1)), r), 8'(i + 32), 1'b1, 1'b0);
            if (i > 0) chk("stream_ready", 64'(in_ready), 64'd1);
        end
        cycle(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        // Flush with two queued entries and a concurrent push
        cycle(1'b1, mk(I_CBZ, 32'h7 << 5), 8'h41, 1'b0, 1'b0);
        cycle(1'b1, mk(I_CBZ, 32'h8 << 5), 8'h42, 1'b0, 1'b0);
        cycle(1'b1, mk(I_CBZ, 32'h9 << 5), 8'hEE, 1'b0, 1'b1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        cycle(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of traffic
        cycle(1'b1, mk(I_B, 32'h123), 8'h77, 1'b0, 1'b0);
        cycle(1'b1, mk(I_B, 32'h456), 8'h78, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_imm", imm, 64'd0);
        chk("arst_class", 64'(imm_class), 64'd0);
        chk("arst_tag", 64'(out_tag), 64'd0);
        q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized traffic against the queue model
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            if ($urandom_range(0, 7) != 0) r = mk(int'($urandom_range(0, NOPS - 1)), $urandom);
            cycle(1'($urandom_range(0, 3) != 0), r, 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
